fmap_receiver: RTL and testbench

//  Sink end of the pixel stream produced by the fmap feeder (o_pixel/o_out_valid).

---
 rtl/fmap_pkg.sv | 22 ++
 rtl/fmap_rx_ram.sv | 47 ++++
 rtl/fmap_receiver.sv | 241 ++++++++++++++++++++++++
 tb/tb_fmap_receiver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
// ---------------------------------------------------------------------------
// fmap_pkg
// Shared definitions for the feature-map stream blocks (feeder, receiver,
// CNN top): frame geometry, pixel width, idle-gap limit and the receiver
// state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package fmap_pkg;

  localparam int I_F_BW       = 8;
  localparam int IX           = 28;
  localparam int IY           = 28;
  localparam int TOTAL_PIXELS = IX * IY;
  localparam int RX_TIMEOUT   = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } rx_state_e;

endpackage : fmap_pkg

// File: rtl/fmap_rx_ram.sv
// ---------------------------------------------------------------------------
// fmap_rx_ram
// Simple dual-port frame buffer: one write port, one synchronous read port.
// Written as a plain block-RAM template (no reset on the array or on the
// read register) so synthesis maps it onto a BRAM primitive.
// A read and a write to the same address in one cycle return the old data.
// Ports:
//   clk    in   1     clock, rising edge
//   we     in   1     write enable
//   waddr  in   AW    write address
//   wdata  in   DW    write data
//   re     in   1     read enable (read register holds when low)
//   raddr  in   AW    read address (caller keeps it below DEPTH)
//   rdata  out  DW    read data, one cycle after re
// ---------------------------------------------------------------------------
module fmap_rx_ram
  import fmap_pkg::*;
#(
  parameter int DW    = I_F_BW,
  parameter int DEPTH = TOTAL_PIXELS,
  parameter int AW    = $clog2(TOTAL_PIXELS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array write and registered read; non-blocking read gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : fmap_rx_ram

// File: rtl/fmap_receiver.sv
// ---------------------------------------------------------------------------
// fmap_receiver
// Sink for the fmap pixel stream. Captures one IX*IY frame in raster order
// into fmap_rx_ram, flags completion, holds the frame until released with
// i_clear, and offers a latency-1 random-access read port.
// Optional feature: define FMAP_RX_TIMEOUT_EN to abort a capture after
// TIMEOUT consecutive idle cycles (sets o_short_frame). Without the macro a
// capture waits indefinitely and o_short_frame stays 0.
// Ports:
//   clk            in   1       clock, rising edge
//   reset          in   1       asynchronous, active-high reset
//   i_pixel        in   I_F_BW  stream pixel, taken when i_valid=1
//   i_valid        in   1       pixel strobe (no backpressure)
//   i_clear        in   1       release held frame / clear sticky flags
//   i_rd_en        in   1       read request
//   i_rd_addr      in   AW      read address, y*IX+x
//   o_rd_data      out  I_F_BW  read data (0 for addresses past the frame)
//   o_rd_valid     out  1       qualifies o_rd_data
//   o_frame_done   out  1       one-cycle pulse after the last pixel write
//   o_busy         out  1       capture in progress
//   o_full         out  1       frame held
//   o_overflow     out  1       sticky: pixel arrived while frame held
//   o_short_frame  out  1       sticky: capture aborted by idle timeout
//   o_pixel_cnt    out  AW+1    pixels written in the current frame
// ---------------------------------------------------------------------------
module fmap_receiver
  import fmap_pkg::*;
#(
  parameter int I_F_BW       = fmap_pkg::I_F_BW,
  parameter int IX           = fmap_pkg::IX,
  parameter int IY           = fmap_pkg::IY,
  parameter int TOTAL_PIXELS = IX * IY,
`ifdef FMAP_RX_TIMEOUT_EN
  parameter int TIMEOUT      = RX_TIMEOUT,
`endif
  parameter int AW           = $clog2(TOTAL_PIXELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [I_F_BW-1:0] i_pixel,
  input  logic              i_valid,
  input  logic              i_clear,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [I_F_BW-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_short_frame,
  output logic [AW:0]       o_pixel_cnt
);

  localparam logic [AW:0]   TOTAL_W   = (AW + 1)'(TOTAL_PIXELS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL_PIXELS - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  rx_state_e         state_q, state_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              short_q, short_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_hit_q, rd_hit_d;

`ifdef FMAP_RX_TIMEOUT_EN
  localparam int             GW       = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0]  GAP_ONE  = GW'(1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(TIMEOUT - 1);
  logic [GW-1:0]     gap_q, gap_d;
`endif

  logic              wr_en_s;
  logic [AW-1:0]     wr_addr_s;
  logic [AW:0]       cnt_base_s;
  logic              last_s;
  logic [AW-1:0]     adv_addr_s;
  logic [AW:0]       adv_cnt_s;
  logic              rd_in_frame_s;
  logic [I_F_BW-1:0] ram_rdata_s;

  // Write-side address/count for the pixel on i_valid. In IDLE the strobe
  // is pixel 0 of a new frame, so address and count restart from zero.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_addr_s  = '0;
    cnt_base_s = '0;
    if (state_q == CAPTURE) begin
      wr_en_s    = i_valid;
      wr_addr_s  = wr_addr_q;
      cnt_base_s = cnt_q;
    end else if (state_q == IDLE) begin
      wr_en_s    = i_valid;
    end else begin
      wr_en_s    = 1'b0;
    end
    last_s        = (wr_addr_s == LAST_ADDR);
    adv_addr_s    = last_s ? '0 : (wr_addr_s + ADDR_ONE);
    adv_cnt_s     = (cnt_base_s == TOTAL_W) ? cnt_base_s : (cnt_base_s + CNT_ONE);
    rd_in_frame_s = ({1'b0, i_rd_addr} < TOTAL_W);
  end

  // Next-state logic for the capture FSM, counters and sticky flags.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    short_d    = short_q;
`ifdef FMAP_RX_TIMEOUT_EN
    gap_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (i_clear) begin
          cnt_d      = '0;
          overflow_d = 1'b0;
          short_d    = 1'b0;
        end else begin
          cnt_d      = cnt_q;
        end
        if (i_valid) begin
          state_d   = last_s ? FULL : CAPTURE;
          wr_addr_d = adv_addr_s;
          cnt_d     = adv_cnt_s;
          done_d    = last_s;
        end else begin
          state_d   = IDLE;
        end
      end
      CAPTURE: begin
        // i_clear is deliberately ignored here: the frame keeps going.
        if (i_valid) begin
          state_d   = last_s ? FULL : CAPTURE;
          wr_addr_d = adv_addr_s;
          cnt_d     = adv_cnt_s;
          done_d    = last_s;
        end else begin
`ifdef FMAP_RX_TIMEOUT_EN
          if (gap_q == GAP_LAST) begin
            state_d   = IDLE;
            wr_addr_d = '0;
            cnt_d     = '0;
            short_d   = 1'b1;
          end else begin
            gap_d     = gap_q + GAP_ONE;
          end
`else
          state_d = CAPTURE;
`endif
        end
      end
      FULL: begin
        // Clear takes priority over a coincident pixel, which is dropped.
        if (i_clear) begin
          state_d    = IDLE;
          cnt_d      = '0;
          overflow_d = 1'b0;
          short_d    = 1'b0;
        end else if (i_valid) begin
          overflow_d = 1'b1;
        end else begin
          state_d    = FULL;
        end
      end
      default: begin
        state_d   = IDLE;
        wr_addr_d = '0;
        cnt_d     = '0;
      end
    endcase
    busy_d     = (state_d == CAPTURE);
    full_d     = (state_d == FULL);
    rd_valid_d = i_rd_en;
    rd_hit_d   = i_rd_en & rd_in_frame_s;
  end

  // State, counter, flag and read-pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
`ifdef FMAP_RX_TIMEOUT_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      rd_hit_q   <= rd_hit_d;
`ifdef FMAP_RX_TIMEOUT_EN
      gap_q      <= gap_d;
`endif
    end
  end

  // Out-of-frame reads never touch the array; rd_hit_q forces their data to 0.
  fmap_rx_ram #(
    .DW    (I_F_BW),
    .DEPTH (TOTAL_PIXELS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_addr_s),
    .wdata (i_pixel),
    .re    (rd_hit_d),
    .raddr (i_rd_addr),
    .rdata (ram_rdata_s)
  );

  assign o_rd_data     = rd_hit_q ? ram_rdata_s : '0;
  assign o_rd_valid    = rd_valid_q;
  assign o_frame_done  = done_q;
  assign o_busy        = busy_q;
  assign o_full        = full_q;
  assign o_overflow    = overflow_q;
  assign o_short_frame = short_q;
  assign o_pixel_cnt   = cnt_q;

endmodule : fmap_receiver

// File: tb/tb_fmap_receiver.sv
// ---------------------------------------------------------------------------
// tb_fmap_receiver
// Self-checking bench for fmap_receiver (default 28x28, 8-bit pixels).
// Read expectations go through a scoreboard queue; a table of read vectors
// covers the captured frame, plus hand-written sequences for overflow,
// clear priority, mid-frame reset, read-during-write and the idle timeout
// (expectations follow FMAP_RX_TIMEOUT_EN when it is defined).
// ---------------------------------------------------------------------------
module tb_fmap_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_pixel;
  logic        i_valid;
  logic        i_clear;
  logic        i_rd_en;
  logic [9:0]  i_rd_addr;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        o_frame_done;
  logic        o_busy;
  logic        o_full;
  logic        o_overflow;
  logic        o_short_frame;
  logic [10:0] o_pixel_cnt;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0] sb_q [$];

  typedef struct {
    logic [9:0] addr;
    logic [7:0] exp;
  } rd_vec_t;
  rd_vec_t tbl [8];

  fmap_receiver dut (
    .clk           (clk),
    .reset         (reset),
    .i_pixel       (i_pixel),
    .i_valid       (i_valid),
    .i_clear       (i_clear),
    .i_rd_en       (i_rd_en),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_frame_done  (o_frame_done),
    .o_busy        (o_busy),
    .o_full        (o_full),
    .o_overflow    (o_overflow),
    .o_short_frame (o_short_frame),
    .o_pixel_cnt   (o_pixel_cnt)
  );

  always #5 clk = ~clk;

  // Count done pulses away from the active edge.
  always @(negedge clk) begin
    if (o_frame_done === 1'b1) done_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, step past the edge, score any read response.
  task automatic cycle(input logic v, input logic [7:0] pix, input logic rd,
                       input logic [9:0] ra, input logic [7:0] rexp, input logic clr);
    logic [7:0] e;
    i_valid = v; i_pixel = pix; i_rd_en = rd; i_rd_addr = ra; i_clear = clr;
    if (rd) sb_q.push_back(rexp);
    @(posedge clk); #1;
    i_valid = 1'b0; i_rd_en = 1'b0; i_clear = 1'b0;
    if (rd) begin
      chk("rd_valid", {31'd0, o_rd_valid}, 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (o_rd_valid) chk("rd_data", {24'd0, o_rd_data}, {24'd0, e});
      end
    end else begin
      chk("rd_valid_idle", {31'd0, o_rd_valid}, 32'd0);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [9:0] a, input logic [7:0] e);
    cycle(1'b0, 8'h00, 1'b1, a, e, 1'b0);
  endtask

  task automatic send(input int n, input logic use_c, input logic [7:0] cval, input logic gaps);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, use_c ? cval : 8'(i), 1'b0, 10'd0, 8'h00, 1'b0);
      if (gaps && (i % 100 == 99)) repeat (5) idle();
    end
  endtask

  initial begin
    tbl[0] = '{10'd0,    8'h00};
    tbl[1] = '{10'd27,   8'h1B};
    tbl[2] = '{10'd28,   8'h1C};
    tbl[3] = '{10'd783,  8'h0F};
    tbl[4] = '{10'd500,  8'hF4};
    tbl[5] = '{10'd255,  8'hFF};
    tbl[6] = '{10'd784,  8'h00};
    tbl[7] = '{10'd1023, 8'h00};

    reset = 1'b1; i_valid = 1'b0; i_pixel = 8'h00; i_clear = 1'b0;
    i_rd_en = 1'b0; i_rd_addr = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  {31'd0, o_busy}, 32'd0);
    chk("rst_full",  {31'd0, o_full}, 32'd0);
    chk("rst_done",  {31'd0, o_frame_done}, 32'd0);
    chk("rst_ovf",   {31'd0, o_overflow}, 32'd0);
    chk("rst_short", {31'd0, o_short_frame}, 32'd0);
    chk("rst_cnt",   {21'd0, o_pixel_cnt}, 32'd0);
    chk("rst_rdv",   {31'd0, o_rd_valid}, 32'd0);
    chk("rst_rdd",   {24'd0, o_rd_data}, 32'd0);
    reset = 1'b0;
    idle();

    // Test 1: back-to-back frame, value = addr[7:0].
    send(1, 1'b0, 8'h00, 1'b0);
    chk("t1_busy_first", {31'd0, o_busy}, 32'd1);
    chk("t1_cnt_first",  {21'd0, o_pixel_cnt}, 32'd1);
    for (int i = 1; i < 783; i++) cycle(1'b1, 8'(i), 1'b0, 10'd0, 8'h00, 1'b0);
    chk("t1_cnt_783",   {21'd0, o_pixel_cnt}, 32'd783);
    chk("t1_busy_783",  {31'd0, o_busy}, 32'd1);
    chk("t1_nodone",    {31'd0, o_frame_done}, 32'd0);
    cycle(1'b1, 8'h0F, 1'b0, 10'd0, 8'h00, 1'b0);
    chk("t1_done",      {31'd0, o_frame_done}, 32'd1);
    chk("t1_full",      {31'd0, o_full}, 32'd1);
    chk("t1_busy_end",  {31'd0, o_busy}, 32'd0);
    chk("t1_cnt",       {21'd0, o_pixel_cnt}, 32'd784);
    idle();
    chk("t1_done_once", {31'd0, o_frame_done}, 32'd0);
    chk("t1_full_hold", {31'd0, o_full}, 32'd1);
    chk("t1_done_cnt",  done_cnt, 32'd1);
    for (int k = 0; k < 8; k++) rd(tbl[k].addr, tbl[k].exp);

    // Test 3: overflow while full, then clear.
    cycle(1'b1, 8'hAA, 1'b0, 10'd0, 8'h00, 1'b0);
    chk("t3_ovf_set", {31'd0, o_overflow}, 32'd1);
    cycle(1'b1, 8'hAA, 1'b0, 10'd0, 8'h00, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 10'd0, 8'h00, 1'b0);
    chk("t3_ovf",     {31'd0, o_overflow}, 32'd1);
    chk("t3_cnt",     {21'd0, o_pixel_cnt}, 32'd784);
    chk("t3_full",    {31'd0, o_full}, 32'd1);
    rd(10'd0, 8'h00);
    rd(10'd1, 8'h01);
    cycle(1'b0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b1);
    chk("t3_ovf_clr", {31'd0, o_overflow}, 32'd0);
    chk("t3_full_clr",{31'd0, o_full}, 32'd0);
    chk("t3_busy_clr",{31'd0, o_busy}, 32'd0);
    chk("t3_cnt_clr", {21'd0, o_pixel_cnt}, 32'd0);

    // Test 2: same stream with 5-cycle gaps after every 100 pixels.
    send(783, 1'b0, 8'h00, 1'b1);
    chk("t2_no_early_done", done_cnt, 32'd1);
    chk("t2_busy",      {31'd0, o_busy}, 32'd1);
    chk("t2_cnt_783",   {21'd0, o_pixel_cnt}, 32'd783);
    cycle(1'b1, 8'h0F, 1'b0, 10'd0, 8'h00, 1'b0);
    chk("t2_done",      {31'd0, o_frame_done}, 32'd1);
    idle();
    chk("t2_done_cnt",  done_cnt, 32'd2);
    rd(10'd0, 8'h00); rd(10'd28, 8'h1C); rd(10'd783, 8'h0F); rd(10'd399, 8'h8F);

    // Clear and valid together in FULL: clear wins, pixel dropped.
    cycle(1'b1, 8'hEE, 1'b0, 10'd0, 8'h00, 1'b1);
    chk("cv_ovf",  {31'd0, o_overflow}, 32'd0);
    chk("cv_full", {31'd0, o_full}, 32'd0);
    chk("cv_busy", {31'd0, o_busy}, 32'd0);
    chk("cv_cnt",  {21'd0, o_pixel_cnt}, 32'd0);
    rd(10'd0, 8'h00);

    // Test 4: reset after 300 pixels, then a full frame of 0x55.
    send(300, 1'b1, 8'hC3, 1'b0);
    chk("t4_cnt300", {21'd0, o_pixel_cnt}, 32'd300);
    reset = 1'b1;
    #2;
    chk("t4_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("t4_rst_cnt",  {21'd0, o_pixel_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(); idle();
    chk("t4_no_done", done_cnt, 32'd2);
    send(784, 1'b1, 8'h55, 1'b0);
    chk("t4_full", {31'd0, o_full}, 32'd1);
    idle();
    chk("t4_done_cnt", done_cnt, 32'd3);
    rd(10'd299, 8'h55); rd(10'd0, 8'h55); rd(10'd783, 8'h55);

    // Test 5: out-of-range read, then read/write collision.
    rd(10'd900, 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b1);
    send(10, 1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h11, 1'b1, 10'd10, 8'h55, 1'b0);
    cycle(1'b1, 8'h11, 1'b1, 10'd10, 8'h11, 1'b0);
    chk("t5_cnt", {21'd0, o_pixel_cnt}, 32'd12);
    rd(10'd11, 8'h11);
    rd(10'd12, 8'h55);

    // Test 6: 200 pixels then a 64-cycle idle gap.
    send(188, 1'b1, 8'h22, 1'b0);
    chk("t6_cnt200", {21'd0, o_pixel_cnt}, 32'd200);
    repeat (63) idle();
    chk("t6_busy_63", {31'd0, o_busy}, 32'd1);
    idle();
`ifdef FMAP_RX_TIMEOUT_EN
    chk("t6_short", {31'd0, o_short_frame}, 32'd1);
    chk("t6_busy",  {31'd0, o_busy}, 32'd0);
    chk("t6_cnt",   {21'd0, o_pixel_cnt}, 32'd0);
`else
    chk("t6_short", {31'd0, o_short_frame}, 32'd0);
    chk("t6_busy",  {31'd0, o_busy}, 32'd1);
    chk("t6_cnt",   {21'd0, o_pixel_cnt}, 32'd200);
`endif
    chk("t6_full", {31'd0, o_full}, 32'd0);
    chk("t6_done_cnt", done_cnt, 32'd3);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fmap_receiver
